div: RTL

Multi-cycle radix-2 restoring divider serving the EX stage for DIV/DIVU. EX raises a start request with both operands and holds it. The divider iterates one quotient bit per cycle and then presents a 64-bit {remainder, quotient} result with a ready flag. EX writes that result to HI/LO and keeps the pipeline stalled until ready.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared defines for the EX-stage divider
// State encodings, handshake levels and datapath widths used by div.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  function automatic logic [RegBus-1:0] neg_word(input logic [RegBus-1:0] v);
    return (~v) + RegBus'(1);
  endfunction

endpackage

// File: rtl/div.sv
// rtl/div.sv - radix-2 restoring divider for DIV/DIVU
// One quotient bit per cycle; registered {remainder, quotient} with a ready flag.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  logic [1:0]              state_q,   state_d;
  logic [4:0]              cnt_q,     cnt_d;
  logic [64:0]             work_q,    work_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    neg1_q,    neg1_d;
  logic                    neg2_q,    neg2_d;
  logic                    signed_q,  signed_d;
  logic [DoubleRegBus-1:0] result_q,  result_d;
  logic                    ready_q,   ready_d;

  logic [RegBus-1:0] op1_mag;
  logic [RegBus-1:0] op2_mag;
  logic [32:0]       diff;
  logic [64:0]       work_step;
  logic [RegBus-1:0] quot;
  logic [RegBus-1:0] rem;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[31]) ? neg_word(opdata1_i) : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[31]) ? neg_word(opdata2_i) : opdata2_i;

    // work[63:32] is the partial remainder with the next dividend bit shifted in
    diff      = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    work_step = diff[32] ? {work_q[63:0], 1'b0}
                         : {diff[31:0], work_q[31:0], 1'b1};

    quot     = work_step[31:0];
    rem      = work_step[64:33];
    quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? neg_word(quot) : quot;
    rem_fix  = (signed_q && neg1_q) ? neg_word(rem) : rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DivFree: begin
        result_d = {ZeroWord, ZeroWord};
        ready_d  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          neg1_d   = opdata1_i[31];
          neg2_d   = opdata2_i[31];
          signed_d = signed_div_i;
          if (opdata2_i == ZeroWord) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = 5'd0;
            work_d    = {ZeroWord, op1_mag, 1'b0};
            divisor_d = op2_mag;
          end
        end
      end

      DivByZero: begin
        result_d = {ZeroWord, ZeroWord};
        state_d  = annul_i ? DivFree : DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = {ZeroWord, ZeroWord};
          ready_d  = DivResultNotReady;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {rem_fix, quot_fix};
            ready_d  = DivResultReady;
            state_d  = DivEnd;
          end
        end
      end

      DivEnd: begin
        // divide-by-zero reaches here with ready still low; it rises one edge later
        if (start_i == DivStart) begin
          ready_d = DivResultReady;
        end else begin
          state_d  = DivFree;
          result_d = {ZeroWord, ZeroWord};
          ready_d  = DivResultNotReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= 5'd0;
      work_q    <= '0;
      divisor_q <= ZeroWord;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
